// File: rtl/fpga_pkg.sv
// Shared types and constants for the ADC-to-Pi bridge.
// Imported by the top and the SPI frame engine.
package fpga_pkg;

  typedef enum logic [1:0] {
    GAP_A,
    ADC_XFER,
    GAP_P,
    PI_XFER
  } state_t;

  localparam logic [15:0] ADC_CMD = 16'hD000;
  localparam int FRAME_BITS = 16;
  localparam int SAMPLE_BITS = 10;
  localparam int FIRST_SAMPLE_EDGE = 7;

  typedef struct packed {
    logic       stb;
    logic [4:0] idx;
    logic       dat;
  } smp_t;

endpackage

// File: rtl/fpga_if.sv
// Four-wire SPI bus bundle.
// Master drives clock, data-out and chip-select.
interface fpga_if;
  logic sclk;
  logic mosi;
  logic ncs;
  logic miso;

  modport master (
    output sclk,
    output mosi,
    output ncs,
    input  miso
  );

  modport slave (
    input  sclk,
    input  mosi,
    input  ncs,
    output miso
  );
endinterface

// File: rtl/fpga_spi_frame_master.sv
// One 16-bit SPI mode-0 frame per start pulse.
// Strobes on every rising SCLK with a 1-based edge index.
module spi_frame_master
  import fpga_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [FRAME_BITS-1:0] tx_word_i,
  fpga_if.master                bus,
  output smp_t                  smp_o,
  output logic                  done_o
);

  localparam logic [4:0] LAST_PH = 5'(2 * FRAME_BITS - 1);
  localparam logic [7:0] HC_END = 8'(CLK_DIV - 1);

  logic                  act_q, act_d;
  logic [7:0]            hc_q, hc_d;
  logic [4:0]            ph_q, ph_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  ncs_q, ncs_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic                  half_end;

  assign half_end = act_q && (hc_q == HC_END);

  // Half-period timing, SCLK toggling and MSB-first shift-out
  always_comb begin
    act_d  = act_q;
    hc_d   = hc_q;
    ph_d   = ph_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    ncs_d  = ncs_q;
    sh_d   = sh_q;
    if (start_i && !act_q) begin
      act_d  = 1'b1;
      hc_d   = '0;
      ph_d   = '0;
      ncs_d  = 1'b0;
      sclk_d = 1'b0;
      mosi_d = tx_word_i[FRAME_BITS-1];
      sh_d   = {tx_word_i[FRAME_BITS-2:0], 1'b0};
    end else if (act_q) begin
      if (half_end) begin
        hc_d = '0;
        ph_d = ph_q + 5'd1;
        if (!ph_q[0]) begin
          sclk_d = 1'b1;
        end else if (ph_q == LAST_PH) begin
          act_d  = 1'b0;
          ncs_d  = 1'b1;
          sclk_d = 1'b0;
          mosi_d = 1'b0;
        end else begin
          sclk_d = 1'b0;
          mosi_d = sh_q[FRAME_BITS-1];
          sh_d   = {sh_q[FRAME_BITS-2:0], 1'b0};
        end
      end else begin
        hc_d = hc_q + 8'd1;
      end
    end
  end

  // Frame state registers, idle bus on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q  <= 1'b0;
      hc_q   <= '0;
      ph_q   <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      ncs_q  <= 1'b1;
      sh_q   <= '0;
    end else begin
      act_q  <= act_d;
      hc_q   <= hc_d;
      ph_q   <= ph_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      ncs_q  <= ncs_d;
      sh_q   <= sh_d;
    end
  end

  assign bus.sclk  = sclk_q;
  assign bus.mosi  = mosi_q;
  assign bus.ncs   = ncs_q;
  assign smp_o.stb = half_end && !ph_q[0];
  assign smp_o.idx = {1'b0, ph_q[4:1]} + 5'd1;
  assign smp_o.dat = bus.miso;
  assign done_o    = half_end && (ph_q == LAST_PH);

endmodule

// File: rtl/fpga_top.sv
// Free-running ADC sampler forwarding each result to a Pi over SPI.
// Alternates gap / ADC frame / gap / Pi frame forever.
module fpga_top
  import fpga_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dinAdc,
  output logic       sclkAdc,
  output logic       doutAdc,
  output logic       ncsAdc,
  output logic       sclkPi,
  output logic       doutPi,
  output logic       ncsPi,
  output logic [7:0] led
);

  localparam logic [15:0] GAP_END = 16'(GAP_CYC - 1);

  fpga_if adc_bus ();
  fpga_if pi_bus ();

  state_t                 state_q, state_d;
  logic [15:0]            gcnt_q;
  logic [SAMPLE_BITS-1:0] smp_q;
  logic [SAMPLE_BITS-1:0] held_q;
  logic [7:0]             led_q;
  logic                   gap_end;
  logic                   adc_start, pi_start;
  logic                   adc_done, pi_done;
  smp_t                   adc_smp;
  smp_t                   pi_unused;

  assign gap_end = (gcnt_q == GAP_END);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= GAP_A;
    else        state_q <= state_d;
  end

  // Next-state logic: fixed four-phase rotation
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GAP_A:    if (gap_end)  state_d = ADC_XFER;
      ADC_XFER: if (adc_done) state_d = GAP_P;
      GAP_P:    if (gap_end)  state_d = PI_XFER;
      PI_XFER:  if (pi_done)  state_d = GAP_A;
    endcase
  end

  // Output logic: launch a frame on the last gap cycle
  always_comb begin
    adc_start = 1'b0;
    pi_start  = 1'b0;
    unique case (1'b1)
      (state_q == GAP_A): adc_start = gap_end;
      (state_q == GAP_P): pi_start  = gap_end;
      default: ;
    endcase
  end

  // Gap cycle counter, idle during transfers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gcnt_q <= '0;
    end else if (state_q == GAP_A || state_q == GAP_P) begin
      gcnt_q <= gap_end ? '0 : gcnt_q + 16'd1;
    end else begin
      gcnt_q <= '0;
    end
  end

  // Capture late ADC bits; commit only on a completed frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_q  <= '0;
      held_q <= '0;
      led_q  <= '0;
    end else begin
      if (adc_smp.stb && adc_smp.idx >= 5'(FIRST_SAMPLE_EDGE))
        smp_q <= {smp_q[SAMPLE_BITS-2:0], adc_smp.dat};
      if (adc_done) begin
        held_q <= smp_q;
        led_q  <= smp_q[SAMPLE_BITS-1:SAMPLE_BITS-8];
      end
    end
  end

  spi_frame_master #(.CLK_DIV(CLK_DIV)) u_adc (
    .clk       (clk),
    .reset     (reset),
    .start_i   (adc_start),
    .tx_word_i (ADC_CMD),
    .bus       (adc_bus),
    .smp_o     (adc_smp),
    .done_o    (adc_done)
  );

  spi_frame_master #(.CLK_DIV(CLK_DIV)) u_pi (
    .clk       (clk),
    .reset     (reset),
    .start_i   (pi_start),
    .tx_word_i ({{(FRAME_BITS-SAMPLE_BITS){1'b0}}, held_q}),
    .bus       (pi_bus),
    .smp_o     (pi_unused),
    .done_o    (pi_done)
  );

  assign adc_bus.miso = dinAdc;
  assign pi_bus.miso  = 1'b0;
  assign sclkAdc      = adc_bus.sclk;
  assign doutAdc      = adc_bus.mosi;
  assign ncsAdc       = adc_bus.ncs;
  assign sclkPi       = pi_bus.sclk;
  assign doutPi       = pi_bus.mosi;
  assign ncsPi        = pi_bus.ncs;
  assign led          = led_q;

endmodule

// File: tb/tb_fpga_top.sv
// Directed bench for fpga_top: reset, captures, loop timing.
// SPI traffic is decoded on rising SCLK like a mode-0 slave.
module tb_fpga_top;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dinAdc = 1'b0;
  logic [7:0]  led;
  logic [15:0] fr_cnt = '0;
  int          total = 0;
  int          bad = 0;

  fpga_if adc_if ();
  fpga_if pi_if ();

  assign adc_if.miso = dinAdc;
  assign pi_if.miso  = 1'b0;

  fpga_top #(.CLK_DIV(4), .GAP_CYC(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .dinAdc  (dinAdc),
    .sclkAdc (adc_if.sclk),
    .doutAdc (adc_if.mosi),
    .ncsAdc  (adc_if.ncs),
    .sclkPi  (pi_if.sclk),
    .doutPi  (pi_if.mosi),
    .ncsPi   (pi_if.ncs),
    .led     (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) fr_cnt <= fr_cnt + 16'd1;

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {adc_if.ncs, pi_if.ncs, adc_if.sclk, pi_if.sclk,
            adc_if.mosi, pi_if.mosi, led};
  endfunction

  task automatic wait_fall(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (adc_if.ncs && n < 40);
  endtask

  // Runs from ADC frame cycle 0 to the next ADC frame cycle 0
  task automatic do_loop(input logic [15:0] word, input bit free,
                         output int n, output logic [15:0] cmd,
                         output logic [15:0] piw, output int r_adc,
                         output int r_pi, output logic [7:0] led_pre,
                         output logic [7:0] led_end, output int n_arise,
                         output int n_prise, output int ovl);
    logic p_sa, p_sp, p_na, p_np;
    logic [7:0] led_prev;
    n = 0; cmd = '0; piw = '0; r_adc = 0; r_pi = 0;
    led_pre = '0; led_end = '0; n_arise = 0; n_prise = 0; ovl = 0;
    dinAdc = free ? fr_cnt[5] : word[15];
    do begin
      p_sa = adc_if.sclk; p_sp = pi_if.sclk;
      p_na = adc_if.ncs;  p_np = pi_if.ncs;
      led_prev = led;
      @(posedge clk); #1;
      n++;
      if (!p_sa && adc_if.sclk) begin
        cmd = {cmd[14:0], adc_if.mosi};
        r_adc++;
      end
      if (!p_sp && pi_if.sclk) begin
        piw = {piw[14:0], pi_if.mosi};
        r_pi++;
      end
      if (free) dinAdc = fr_cnt[5];
      else dinAdc = (r_adc < 16) ? word[15-r_adc] : 1'b0;
      if (!adc_if.ncs && !pi_if.ncs) ovl++;
      if (adc_if.ncs && adc_if.sclk) ovl++;
      if (pi_if.ncs && pi_if.sclk) ovl++;
      if (!p_na && adc_if.ncs) begin
        led_pre = led_prev;
        led_end = led;
        n_arise = n;
      end
      if (!p_np && pi_if.ncs) n_prise = n;
    end while (!(p_na && !adc_if.ncs) && n < 400);
  endtask

  initial begin
    int n, ra, rp, na, np, ov, r;
    logic [15:0] cmd, piw;
    logic [7:0] lp, le;
    logic p_sa;

    // Held reset with a toggling input: bus stays idle
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      dinAdc = ~dinAdc;
      chk("rst_outs", 32'(outs()), 32'h3000);
    end
    reset = 1'b1;
    wait_fall(n);
    chk("rel_to_ncs", n, 8);

    // Reset in the middle of bit 10 of the first ADC frame
    dinAdc = 1'b1;
    r = 0; n = 0;
    while (r < 10 && n < 200) begin
      p_sa = adc_if.sclk;
      @(posedge clk); #1;
      n++;
      if (!p_sa && adc_if.sclk) r++;
    end
    chk("reach_bit10", r, 10);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midrst_ncs", adc_if.ncs, 1'b1);
    chk("midrst_outs", 32'(outs()), 32'h3000);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("midrst_led", led, 8'h00);
    wait_fall(n);
    chk("midrst_restart", n, 8);
    chk("midrst_led2", led, 8'h00);

    // All-ones input
    do_loop(16'hFFFF, 1'b0, n, cmd, piw, ra, rp, lp, le, na, np, ov);
    chk("ones_period", n, 272);
    chk("ones_cmd", cmd, 16'hD000);
    chk("ones_led", le, 8'hFF);
    chk("ones_piw", piw, 16'h03FF);
    chk("ones_adc_pulses", ra, 16);
    chk("ones_pi_pulses", rp, 16);
    chk("ones_adc_len", na, 128);
    chk("ones_pi_end", np, 264);
    chk("ones_overlap", ov, 0);

    // All-zeros input: old result persists until ADC frame end
    chk("zero_led_start", led, 8'hFF);
    do_loop(16'h0000, 1'b0, n, cmd, piw, ra, rp, lp, le, na, np, ov);
    chk("zero_led_pre", lp, 8'hFF);
    chk("zero_led", le, 8'h00);
    chk("zero_piw", piw, 16'h0000);
    chk("zero_cmd", cmd, 16'hD000);
    chk("zero_period", n, 272);

    // Edges 1..6 driven high must be ignored
    do_loop(16'hFE99, 1'b0, n, cmd, piw, ra, rp, lp, le, na, np, ov);
    chk("pat_led", le, 8'hA6);
    chk("pat_piw", piw, 16'h0299);
    chk("pat_cmd", cmd, 16'hD000);
    chk("pat_overlap", ov, 0);

    // Free-running input: timing and bus exclusivity
    for (int k = 0; k < 2; k++) begin
      do_loop(16'h0000, 1'b1, n, cmd, piw, ra, rp, lp, le, na, np, ov);
      chk("free_period", n, 272);
      chk("free_adc_pulses", ra, 16);
      chk("free_pi_pulses", rp, 16);
      chk("free_overlap", ov, 0);
      chk("free_cmd", cmd, 16'hD000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpga_top.md
FPGA_TOP -- requirements
Module: fpga_top

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal values 2 to 255).
REQ-002 Parameter GAP_CYC, default 8, meaning idle clk cycles with chip-select high before each frame.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 dinAdc  input  1  serial data from the ADC (MISO).
REQ-006 sclkAdc  output  1  ADC SPI clock.
REQ-007 doutAdc  output  1  serial command to the ADC (MOSI).
REQ-008 ncsAdc  output  1  ADC chip-select, active-low.
REQ-009 sclkPi  output  1  Pi link SPI clock.
REQ-010 doutPi  output  1  serial sample data to the Pi.
REQ-011 ncsPi  output  1  Pi link chip-select, active-low.
REQ-012 led  output  8  upper 8 bits of the latest ADC sample.

Function
REQ-013 Controller states: GAP_A, ADC_XFER, GAP_P, PI_XFER.
- Cycles continuously in that order; after PI_XFER it returns to GAP_A.
REQ-014 GAP_A and GAP_P each last GAP_CYC clk cycles.
- Both ncs outputs are high and both sclk outputs are low in these states.
REQ-015 Each XFER frame uses SPI mode 0 and carries 16 bits, MSB first:
- ncs falls at frame cycle 0, with the first bit already on dout.
- sclk rises at cycle CLK_DIV and falls at cycle 2*CLK_DIV.
- dout changes only on sclk falling edges.
- The frame ends after 16 SCLK periods (32*CLK_DIV cycles); ncs rises on that same cycle.
REQ-016 ADC command word on doutAdc is 16'hD000: start bit, single-ended, channel 0, MSB-first, then zeros.
REQ-017 dinAdc is sampled on the clk edge where sclkAdc rises, for SCLK rising edges 7 through 16 (1-based).
- These 10 bits are shifted into the 10-bit sample register, MSB first.
- Bits on rising edges 1 through 6 are ignored.
REQ-018 At the end of ADC_XFER the sample register is committed to the held sample, and led = held_sample[9:2] on the same cycle.
REQ-019 The PI_XFER word is {6'b0, held_sample} (bits 15..10 zero).
- A new ADC result is never visible mid-PI frame.
REQ-020 Loop period is 2*GAP_CYC + 64*CLK_DIV clk cycles (272 with defaults).
REQ-021 The ADC and Pi buses are never active simultaneously.
- ncsAdc and ncsPi are never both low.
- An idle sclk stays low.
REQ-022 All outputs are registered; no combinational path from dinAdc to any output.

Reset
REQ-023 While reset=0:
- ncsAdc=ncsPi=1.
- sclkAdc=sclkPi=0.
- doutAdc=doutPi=0.
- led=0, sample register and held sample=0.
- State = GAP_A with the counters cleared.
REQ-024 Reset asserted mid-frame aborts the frame immediately (asynchronously): ncs goes high and no partial sample is committed.
REQ-025 After reset release, the first ncsAdc falling edge occurs GAP_CYC cycles later.

Structure
REQ-026 A shared package fpga_pkg holds:
- the state enum type;
- ADC_CMD=16'hD000;
- FRAME_BITS=16, SAMPLE_BITS=10, FIRST_SAMPLE_EDGE=7.
REQ-027 One sub-module, spi_frame_master, is instantiated twice (ADC and Pi).
- Inputs: clk, reset, start, 16-bit tx_word, miso.
- Outputs: sclk, mosi, ncs, a per-rising-edge sample strobe with the edge index, and done.
- fpga_top holds the state machine, sample capture and led register.

Verification
REQ-028 Reset held low 50 cycles, dinAdc toggling -> all outputs stay at their REQ-023 values; release -> ncsAdc falls exactly 8 cycles later.
REQ-029 dinAdc held 1 for the full loop -> led=8'hFF; Pi word shifted out is 16'h03FF; doutAdc bits observed on sclkAdc rising edges = 16'hD000.
REQ-030 dinAdc held 0 -> led=8'h00 and Pi word 16'h0000; the previous value is kept until the end of the next ADC frame.
REQ-031 dinAdc driven so ADC bits 7..16 = 10'b1010011001 -> held sample 10'h299, led=8'hA6, Pi word 16'h0299.
REQ-032 Free-running with dinAdc = free-running counter bit 5 -> ncs never overlap; loop period measured as 272 cycles; each frame shows 16 sclk pulses.
REQ-033 Reset pulsed during bit 10 of an ADC frame -> ncsAdc high within the same cycle, led unchanged from its reset value of 0, and a clean frame restarts after GAP_CYC cycles.
